serial_pe_ctrl: RTL and testbench

- Sequencer that drives one serial_pe through a list of instructions.
- Each instruction byte N (N≥1) means one dot product of N×32 16-bit element pairs.
- The block walks an instruction memory and generates neuron/weight element addresses, ctl[1:0] and vld_i.
- It collects each pe result into a result buffer and signals completion; it sits between the host/start logic and the serial_pe plus its line memories.

---
 rtl/serial_pe_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_serial_pe_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pe_ctrl.sv
`default_nettype none
// ============================================================================
// serial_pe_ctrl : walks an instruction list and streams element pairs to one
// serial_pe, collecting its results (option: SERIAL_PE_CTRL_PERF_EN)
// Rev 1.0
// ============================================================================
module serial_pe_ctrl #(
  parameter int INST_AW = 4,
  parameter int ADDR_W  = 16,
  parameter int RES_AW  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INST_AW:0]   inst_num,
  input  logic [ADDR_W-1:0]  neuron_base,
  input  logic [ADDR_W-1:0]  weight_base,
  output logic [INST_AW-1:0] inst_addr,
  input  logic [7:0]         inst_data,
  output logic [ADDR_W-1:0]  neuron_addr,
  output logic [ADDR_W-1:0]  weight_addr,
  output logic [1:0]         pe_ctl,
  output logic               pe_vld_i,
  input  logic               pe_vld_o,
  input  logic [31:0]        pe_result,
  output logic               res_we,
  output logic [RES_AW-1:0]  res_addr,
  output logic [31:0]        res_data,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef SERIAL_PE_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [INST_AW:0] c_inst_one = (INST_AW+1)'(1);

  state_t             r_state;
  logic [12:0]        r_iter;
  logic [INST_AW:0]   r_inst_num;
  logic [INST_AW:0]   r_exp_cnt;
  logic [INST_AW:0]   r_wr_cnt;
  logic [RES_AW-1:0]  r_wr_ptr;

  logic               w_in_run;
  logic               w_issue;
  logic               w_skip;
  logic [7:0]         w_inst_m1;
  logic               w_last_elem;
  logic               w_last_inst;
  logic               w_inst_end;
  logic               w_capture;

  always_comb begin
    w_in_run    = (r_state == S_RUN);
    w_issue     = w_in_run && (inst_data != 8'd0);
    w_skip      = w_in_run && (inst_data == 8'd0);
    w_inst_m1   = inst_data - 8'd1;
    w_last_elem = (r_iter[12:5] == w_inst_m1) && (r_iter[4:0] == 5'd31);
    w_last_inst = ({1'b0, inst_addr} == (r_inst_num - c_inst_one));
    w_inst_end  = w_skip || (w_issue && w_last_elem);
    w_capture   = pe_vld_o && ((r_state == S_RUN) || (r_state == S_DRAIN));
  end

  // Issue strobes follow the asynchronous instruction read directly, so the
  // first element leaves in the cycle after start with no bubble between
  // instructions.
  assign pe_vld_i = w_issue;
  assign pe_ctl   = {w_issue && w_last_elem, w_issue && (r_iter == 13'd0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_iter      <= '0;
      r_inst_num  <= '0;
      r_exp_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_wr_ptr    <= '0;
      inst_addr   <= '0;
      neuron_addr <= '0;
      weight_addr <= '0;
      res_we      <= 1'b0;
      res_addr    <= '0;
      res_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      res_we <= 1'b0;
      done   <= 1'b0;

      if (w_capture) begin
        res_we   <= 1'b1;
        res_data <= pe_result;
        res_addr <= r_wr_ptr;
        r_wr_ptr <= r_wr_ptr + RES_AW'(1);
        r_wr_cnt <= r_wr_cnt + c_inst_one;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            err         <= 1'b0;
            inst_addr   <= '0;
            r_iter      <= '0;
            res_addr    <= '0;
            r_wr_ptr    <= '0;
            r_wr_cnt    <= '0;
            r_exp_cnt   <= inst_num;
            r_inst_num  <= inst_num;
            neuron_addr <= neuron_base;
            weight_addr <= weight_base;
            if (inst_num != '0) begin
              r_state <= S_RUN;
              busy    <= 1'b1;
            end else begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (w_issue) begin
            neuron_addr <= neuron_addr + ADDR_W'(1);
            weight_addr <= weight_addr + ADDR_W'(1);
          end
          // A zero-length instruction is flagged and costs one idle cycle.
          if (w_skip) begin
            err       <= 1'b1;
            r_exp_cnt <= r_exp_cnt - c_inst_one;
          end
          if (w_inst_end) begin
            r_iter    <= '0;
            inst_addr <= inst_addr + INST_AW'(1);
            if (w_last_inst) begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_iter <= r_iter + 13'd1;
          end
        end

        S_DRAIN: begin
          if (r_wr_cnt == r_exp_cnt) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_PE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_pe_ctrl.sv
`default_nettype none
// ============================================================================
// tb_serial_pe_ctrl : directed scoreboard bench with a behavioural serial_pe
// Rev 1.0
// ============================================================================
module tb_serial_pe_ctrl;

  localparam int INST_AW = 4;
  localparam int ADDR_W  = 16;
  localparam int RES_AW  = 4;
  localparam int PE_LAT  = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [INST_AW:0]   inst_num = '0;
  logic [ADDR_W-1:0]  neuron_base = '0;
  logic [ADDR_W-1:0]  weight_base = '0;
  logic [INST_AW-1:0] inst_addr;
  logic [7:0]         inst_data;
  logic [ADDR_W-1:0]  neuron_addr;
  logic [ADDR_W-1:0]  weight_addr;
  logic [1:0]         pe_ctl;
  logic               pe_vld_i;
  logic               pe_vld_o = 1'b0;
  logic [31:0]        pe_result = '0;
  logic               res_we;
  logic [RES_AW-1:0]  res_addr;
  logic [31:0]        res_data;
  logic               busy;
  logic               done;
  logic               err;
`ifdef SERIAL_PE_CTRL_PERF_EN
  logic [31:0]        perf_cycles;
`endif

  logic [7:0] imem [16];
  assign inst_data = imem[inst_addr];

  serial_pe_ctrl #(
    .INST_AW (INST_AW),
    .ADDR_W  (ADDR_W),
    .RES_AW  (RES_AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .inst_num    (inst_num),
    .neuron_base (neuron_base),
    .weight_base (weight_base),
    .inst_addr   (inst_addr),
    .inst_data   (inst_data),
    .neuron_addr (neuron_addr),
    .weight_addr (weight_addr),
    .pe_ctl      (pe_ctl),
    .pe_vld_i    (pe_vld_i),
    .pe_vld_o    (pe_vld_o),
    .pe_result   (pe_result),
    .res_we      (res_we),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
`ifdef SERIAL_PE_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RES_AW-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   issue_cnt = 0;
  int   gaps = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;
  int   busy_cyc = 0;
  int   ctl0_idx[$];
  int   ctl1_idx[$];
  int   exp_marks[4];
  logic prev_vld = 1'b0;
  logic prev_busy = 1'b0;
  logic [31:0] acc = '0;
  logic [31:0] pipe_d [PE_LAT];
  logic        pipe_v [PE_LAT];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Result word for a dot product whose neuron and weight address sums are given.
  function automatic logic [31:0] pv(input int nsum, input int wsum);
    return 32'(nsum) + (32'(wsum) << 16);
  endfunction

  task automatic push_exp(input int a, input logic [31:0] d);
    exp_t e;
    e.addr = a[RES_AW-1:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor and behavioural pe: each element contributes neuron_addr +
  // (weight_addr << 16); the sum is returned PE_LAT cycles after the last one.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] val;
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < PE_LAT; i++) begin
        pipe_v[i] = 1'b0;
        pipe_d[i] = '0;
      end
      pe_vld_o  = 1'b0;
      pe_result = '0;
      acc       = '0;
      prev_vld  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (res_we) begin
        wr_cnt++;
        check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("res_addr", 64'(res_addr), 64'(e.addr));
          check("res_data", 64'(res_data), 64'(e.data));
        end
      end
      if (pe_vld_i) begin
        if (!prev_vld && prev_busy) gaps++;
        if (pe_ctl[0]) ctl0_idx.push_back(issue_cnt);
        if (pe_ctl[1]) ctl1_idx.push_back(issue_cnt);
        val = 32'(neuron_addr) + (32'(weight_addr) << 16);
        acc = pe_ctl[0] ? val : acc + val;
        issue_cnt++;
      end
      prev_vld  = pe_vld_i;
      prev_busy = busy;
      pe_vld_o  = pipe_v[PE_LAT-1];
      pe_result = pipe_d[PE_LAT-1];
      for (int i = PE_LAT-1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_d[i] = pipe_d[i-1];
      end
      pipe_v[0] = pe_vld_i && pe_ctl[1];
      pipe_d[0] = acc;
    end
  end

  task automatic check_marks(input string nm, input bit last, input int i0, input int q0, input int n);
    int got;
    int sz;
    sz = last ? ctl1_idx.size() : ctl0_idx.size();
    check({nm, "_count"}, 64'(sz - q0), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (q0 + k < sz) got = (last ? ctl1_idx[q0+k] : ctl0_idx[q0+k]) - i0;
      else             got = -1;
      check(nm, 64'(got), 64'(exp_marks[k]));
    end
  endtask

  task automatic run_case(input string nm, input int n, input logic [15:0] nb, input logic [15:0] wb,
                          input int exp_issues, input int exp_writes, input int exp_gaps,
                          input logic exp_err, input bit extra, output int bc);
    int i0, w0, d0, g0, b0, to;
    i0 = issue_cnt; w0 = wr_cnt; d0 = done_cnt; g0 = gaps; b0 = busy_cyc;
    inst_num    = n[INST_AW:0];
    neuron_base = nb;
    weight_base = wb;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_first_vld"}, 64'(pe_vld_i), 64'((n != 0) && (imem[0] != 8'd0)));
    check({nm, "_busy"}, 64'(busy), 64'(n != 0));
    check({nm, "_done_early"}, 64'(done), 64'(n == 0));
    to = 0;
    while (done_cnt == d0 && to < 3000) begin
      @(negedge clk);
      to++;
      start = extra && (to == 40);
      if (extra && to == 40) inst_num = 5'd1;
    end
    start = 1'b0;
    check({nm, "_timeout"}, 64'(to < 3000), 64'd1);
    repeat (6) @(negedge clk);
    check({nm, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    check({nm, "_issues"}, 64'(issue_cnt - i0), 64'(exp_issues));
    check({nm, "_writes"}, 64'(wr_cnt - w0), 64'(exp_writes));
    check({nm, "_gaps"}, 64'(gaps - g0), 64'(exp_gaps));
    check({nm, "_err"}, 64'(err), 64'(exp_err));
    check({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    check({nm, "_idle"}, 64'({busy, done}), 64'd0);
    bc = busy_cyc - b0;
  endtask

  task automatic load_s2();
    imem[0] = 8'd1; imem[1] = 8'd2; imem[2] = 8'd1; imem[3] = 8'd3;
  endtask

  task automatic push_s2();
    push_exp(0, pv(496, 496));
    push_exp(1, pv(4064, 4064));
    push_exp(2, pv(3568, 3568));
    push_exp(3, pv(16848, 16848));
  endtask

  initial begin
    int i0, q0, q1, bc, to;
    for (int i = 0; i < 16; i++) imem[i] = 8'd0;
    for (int i = 0; i < PE_LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({inst_addr, neuron_addr, weight_addr, pe_ctl, pe_vld_i,
                               res_we, res_addr, busy, done, err}), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single one-line instruction
    imem[0] = 8'd1;
    push_exp(0, pv(496, 496));
    i0 = issue_cnt; q0 = ctl0_idx.size(); q1 = ctl1_idx.size();
    run_case("s1", 1, 16'h0000, 16'h0000, 32, 1, 0, 1'b0, 1'b0, bc);
    exp_marks = '{0, 0, 0, 0};
    check_marks("s1_ctl0", 1'b0, i0, q0, 1);
    exp_marks = '{31, 0, 0, 0};
    check_marks("s1_ctl1", 1'b1, i0, q1, 1);
`ifdef SERIAL_PE_CTRL_PERF_EN
    check("s1_perf", 64'(perf_cycles), 64'(bc));
    repeat (5) @(negedge clk);
    check("s1_perf_hold", 64'(perf_cycles), 64'(bc));
`endif

    // four instructions back to back
    load_s2();
    push_s2();
    i0 = issue_cnt; q0 = ctl0_idx.size(); q1 = ctl1_idx.size();
    run_case("s2", 4, 16'h0000, 16'h0000, 224, 4, 0, 1'b0, 1'b0, bc);
    exp_marks = '{0, 32, 96, 128};
    check_marks("s2_ctl0", 1'b0, i0, q0, 4);
    exp_marks = '{31, 95, 127, 223};
    check_marks("s2_ctl1", 1'b1, i0, q1, 4);

    // zero-length instruction in the middle
    imem[0] = 8'd2; imem[1] = 8'd0; imem[2] = 8'd1; imem[3] = 8'd0;
    push_exp(0, pv(2016, 2016));
    push_exp(1, pv(2544, 2544));
    run_case("s3", 3, 16'h0000, 16'h0000, 96, 2, 1, 1'b1, 1'b0, bc);

    // reset during the second instruction, then rerun
    load_s2();
    push_s2();
    i0 = issue_cnt;
    inst_num = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 0;
    while (issue_cnt - i0 < 50 && to < 500) begin
      @(negedge clk);
      to++;
    end
    check("s4_reach", 64'(to < 500), 64'd1);
    rst_n = 1'b0;
    #1;
    check("s4_rst_outputs", 64'({inst_addr, neuron_addr, weight_addr, pe_ctl, pe_vld_i,
                                  res_we, res_addr, busy, done, err}), 64'd0);
    check("s4_rst_res_data", 64'(res_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_s2();
    run_case("s4_rerun", 4, 16'h0000, 16'h0000, 224, 4, 0, 1'b0, 1'b0, bc);

    // stray start pulse during a run, then an empty run
    push_s2();
    run_case("s5_extra", 4, 16'h0000, 16'h0000, 224, 4, 0, 1'b0, 1'b1, bc);
    run_case("s5_zero", 0, 16'h0000, 16'h0000, 0, 0, 0, 1'b0, 1'b0, bc);

    // full instruction memory
    for (int k = 0; k < 16; k++) begin
      imem[k] = 8'd1;
      push_exp(k, pv(1024*k + 496, 1024*k + 496));
    end
    run_case("s6_full", 16, 16'h0000, 16'h0000, 512, 16, 0, 1'b0, 1'b0, bc);
    check("s6_inst_wrap", 64'(inst_addr), 64'd0);

    // address wrap and distinct bases
    imem[0] = 8'd1;
    push_exp(0, pv(1048560, 149616));
    run_case("s7_wrap", 1, 16'hFFF0, 16'h1234, 32, 1, 0, 1'b0, 1'b0, bc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
